// File: rtl/shift_serializer.sv
// Parallel-in, serial-out frame serializer: loads Size words through a valid/ready
// port and streams them word 0 first on a valid/ready port, flagging the last word.
module shift_serializer #(
  parameter int unsigned Width = 1,
  parameter int unsigned Size  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [Width*Size-1:0]   par_data_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  output logic [Width-1:0]        data_o,
  output logic                    valid_o,
  output logic                    last_o,
  input  logic                    ready_i
);

  localparam int unsigned CntW = (Size > 1) ? $clog2(Size) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(Size - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                  state_r, state_n_s;
  logic [CntW-1:0]         cnt_r, cnt_n_s;
  logic [Width*Size-1:0]   buf_r, buf_n_s;
  logic [Width-1:0]        data_r, data_n_s;
  logic                    valid_r, valid_n_s;
  logic                    last_r, last_n_s;
  logic                    load_ready_s;
  logic                    load_fire_s;
  logic                    beat_s;

  // A new frame may enter when idle or while the final word is leaving.
  assign load_ready_s = (state_r == IDLE) || (valid_r && ready_i && last_r);
  assign load_fire_s  = load_valid_i && load_ready_s;
  assign beat_s       = valid_r && ready_i;

  assign load_ready_o = load_ready_s;
  assign data_o       = data_r;
  assign valid_o      = valid_r;
  assign last_o       = last_r;

  // Next-state, next-count, next-buffer and the next registered output word.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    buf_n_s   = buf_r;
    data_n_s  = {Width{1'b0}};
    valid_n_s = 1'b0;
    last_n_s  = 1'b0;

    if (load_fire_s) begin
      state_n_s = SHIFT;
      cnt_n_s   = {CntW{1'b0}};
      buf_n_s   = par_data_i;
    end else if (beat_s) begin
      if (cnt_r == LastIdx) begin
        state_n_s = IDLE;
        cnt_n_s   = {CntW{1'b0}};
      end else begin
        cnt_n_s   = cnt_r + CntW'(1);
      end
    end else begin
      state_n_s = state_r;
      cnt_n_s   = cnt_r;
    end

    // Outputs are precomputed from the next state so they come straight from flops.
    case (state_n_s)
      SHIFT: begin
        valid_n_s = 1'b1;
        data_n_s  = buf_n_s[cnt_n_s*Width +: Width];
        last_n_s  = (cnt_n_s == LastIdx);
      end
      IDLE: begin
        valid_n_s = 1'b0;
        data_n_s  = {Width{1'b0}};
        last_n_s  = 1'b0;
      end
      default: begin
        valid_n_s = 1'b0;
        data_n_s  = {Width{1'b0}};
        last_n_s  = 1'b0;
      end
    endcase
  end

  // State, count, frame buffer and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      cnt_r   <= {CntW{1'b0}};
      buf_r   <= {(Width*Size){1'b0}};
      data_r  <= {Width{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      buf_r   <= buf_n_s;
      data_r  <= data_n_s;
      valid_r <= valid_n_s;
      last_r  <= last_n_s;
    end
  end

endmodule

// File: doc/shift_serializer.md
Name: shift_serializer

Overview:
- Parallel-in, serial-out companion to the team's serial-in shift register; the transmit end of the same word-stream interface.
- Accepts one frame of Size words in parallel through a valid/ready load port.
- Emits the frame one Width-bit word per accepted beat on a valid/ready stream port, word 0 first, and flags the final word.
- Used wherever a wide parallel result must be streamed into a downstream shift_reg chain or a narrow datapath.

Parameters:
Width, 1, bits per word.
Size, 4, words per frame (Size >= 1).

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_ni  input  1  asynchronous active-low reset.
par_data_i  input  Width*Size  frame to load; word k is par_data_i[k*Width +: Width].
load_valid_i  input  1  frame on par_data_i is valid.
load_ready_o  output  1  serializer can accept a frame this cycle.
data_o  output  Width  current serial word.
valid_o  output  1  data_o holds a valid word.
last_o  output  1  data_o is the final word (index Size-1) of the frame.
ready_i  input  1  downstream accepts data_o this cycle.

Behaviour:
- Reset (asynchronous, active-low): takes effect immediately, independent of clk_i.
  - State = IDLE, count = 0, frame buffer = 0.
  - valid_o = 0, last_o = 0, data_o = 0, load_ready_o = 1.
- Reset mid-frame: aborts the frame with no partial output after the reset edge. After reset release, the serializer is in IDLE.
- State machine:
  - IDLE: valid_o = 0. data_o = 0 whenever valid_o = 0. load_ready_o = 1.
  - SHIFT: valid_o = 1. data_o = buffer[count]. last_o = (count == Size-1).
- Load handshake: a load fires on a rising edge where load_valid_i && load_ready_o.
  - Effect: buffer <= par_data_i, count <= 0, state <= SHIFT.
  - Word 0 appears on data_o with valid_o = 1 in the following cycle (1-cycle load latency).
- load_ready_o is combinational: (state == IDLE) || (valid_o && ready_i && last_o). This lets a new frame load in the same cycle the last word transfers.
- Output handshake: a beat transfers on a rising edge where valid_o && ready_i.
  - count < Size-1: count <= count + 1.
  - count == Size-1, no load: state <= IDLE, count <= 0, valid_o = 0 next cycle.
  - count == Size-1, simultaneous load: state stays SHIFT, buffer reloads, count <= 0. Word 0 of the new frame follows with no bubble.
- Backpressure: while valid_o && !ready_i, data_o, last_o and count hold stable. load_valid_i is ignored (load_ready_o = 0) until the final beat transfers.
- Buffer captures only on a load. par_data_i changing mid-frame has no effect.
- Size = 1: every loaded frame yields exactly one word with last_o = 1. Back-to-back loads then give one word per cycle when ready_i is held high.
- count width: $clog2(Size), minimum 1 bit. count never exceeds Size-1; no wrap beyond it.
- Throughput: one word per cycle when ready_i = 1. A full frame takes Size cycles after the load cycle.
- Outputs data_o, valid_o and last_o are registered (state/count/buffer-driven, no combinational path from ready_i).

Test Plan:
1. Width=8, Size=3. Reset, then load 0x60_A0_F0 (word0 = F0) with ready_i = 1 → data_o F0, A0, 60 on three consecutive cycles; last_o = 1 only with 60; valid_o = 0 afterward; load_ready_o = 1 throughout IDLE.
2. Same frame, ready_i toggled 1,0,0,1,1 → each word holds while ready_i = 0; exactly three transfers F0, A0, 60; load_ready_o = 0 until the 60 beat transfers.
3. Back-to-back: load 0x60_A0_F0, then hold load_valid_i with 0x19_15_C3 during the last beat → stream F0, A0, 60, C3, 15, 19 with valid_o continuously 1 and no bubble.
4. Reset mid-frame: pull rst_ni low after A0 transfers, between clock edges → valid_o, data_o, last_o go to 0 immediately; after release, load 0x20_49_80 → 80, 49, 20, with no leftover 60.
5. Load ignored while busy: change par_data_i and pulse load_valid_i during word 1 → output frame unchanged; no extra load occurs.
6. Size=1, Width=8: load 0x80 then 0x49 on consecutive cycles with ready_i = 1 → data_o 80, then 49, each with last_o = 1 and valid_o continuously 1.
